// File: rtl/stepper_pkg.sv
// Purpose : shared types and saturating speed arithmetic for the stepper move sequencer.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package stepper_pkg;

  localparam int SPEED_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    FINISH
  } move_state_t;

  // min(a + b, ceil). The sum is formed one bit wider so it never wraps.
  // ceil is itself 10 bits, so this also saturates to the 10-bit range.
  function automatic logic [SPEED_W-1:0] speed_add_sat(
    input logic [SPEED_W-1:0] a,
    input logic [SPEED_W-1:0] b,
    input logic [SPEED_W-1:0] ceil
  );
    logic [SPEED_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, ceil}) return ceil;
    return sum[SPEED_W-1:0];
  endfunction

  // max(a - b, floor). The subtraction only happens when a >= floor + b,
  // so it can never underflow.
  function automatic logic [SPEED_W-1:0] speed_sub_floor(
    input logic [SPEED_W-1:0] a,
    input logic [SPEED_W-1:0] b,
    input logic [SPEED_W-1:0] floor
  );
    logic [SPEED_W:0] lim;
    lim = {1'b0, floor} + {1'b0, b};
    if ({1'b0, a} < lim) return floor;
    return a - b;
  endfunction

endpackage

// File: rtl/stepper_ramp_gen.sv
// Purpose : ramp tick divider plus the speed register, with load/up/down/hold and saturation.
// Latency : speed changes one cycle after a load or a tick.
// Backpressure: none; the controls are level inputs and are sampled every cycle.
// Ports   : clk_i/rst_ni are the clock and the synchronous active-low reset.
//           run_i enables the divider. load_i clears the divider and loads SPEED_MIN.
//           up_i/down_i select ramp up or ramp down on each tick. vmax_i is the ramp-up ceiling.
//           speed_o is the current speed.
module stepper_ramp_gen
  import stepper_pkg::*;
#(
  parameter int                  ACCEL_DIV  = 5000,
  parameter logic [SPEED_W-1:0]  ACCEL_STEP = 10'd10,
  parameter logic [SPEED_W-1:0]  SPEED_MIN  = 10'd50
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic               load_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic [SPEED_W-1:0] vmax_i,
  output logic [SPEED_W-1:0] speed_o
);

  localparam int               DIV_W    = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ACCEL_DIV - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               tick;

  assign tick    = run_i && (div_q == DIV_LAST);
  assign speed_o = speed_q;

  always_comb begin
    div_d   = div_q;
    speed_d = speed_q;
    if (load_i) begin
      div_d = '0;
    end else if (run_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // A load wins over a tick, so a new move always starts from SPEED_MIN.
    if (load_i) begin
      speed_d = SPEED_MIN;
    end else if (tick && up_i) begin
      speed_d = speed_add_sat(speed_q, ACCEL_STEP, vmax_i);
    end else if (tick && down_i) begin
      speed_d = speed_sub_floor(speed_q, ACCEL_STEP, SPEED_MIN);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q   <= '0;
      speed_q <= '0;
    end else begin
      div_q   <= div_d;
      speed_q <= speed_d;
    end
  end

endmodule

// File: rtl/stepper_move_sequencer.sv
// Purpose : runs one step/dir driver through a bounded relative move (accel, cruise, decel, stop on count).
// Latency : the driver is enabled at SPEED_MIN one cycle after accept; done pulses one cycle after the last step is counted.
// Backpressure: cmd_ready is high only in IDLE; a command presented while busy is dropped, not queued.
// Ports   : clock/reset_n are the clock and the synchronous active-low reset.
//           cmd_valid/cmd_ready/cmd_steps/cmd_dir/cmd_vmax form the move command. abort requests an early stop.
//           step_fb is the step feedback from the driver. drv_speed/drv_dir/drv_run_en drive the driver.
//           busy and the done/aborted pulse report status. steps_left is the remaining count.
module stepper_move_sequencer
  import stepper_pkg::*;
#(
  parameter int                  ACCEL_DIV  = 5000,
  parameter logic [SPEED_W-1:0]  ACCEL_STEP = 10'd10,
  parameter logic [SPEED_W-1:0]  SPEED_MIN  = 10'd50,
  parameter int                  CNT_W      = 24
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_steps,
  input  logic               cmd_dir,
  input  logic [SPEED_W-1:0] cmd_vmax,
  input  logic               abort,
  input  logic               step_fb,
  output logic [SPEED_W-1:0] drv_speed,
  output logic               drv_dir,
  output logic               drv_run_en,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   steps_left
);

  move_state_t        state_q, state_d;
  logic [CNT_W-1:0]   steps_left_q, steps_left_d;
  logic [CNT_W-1:0]   ramp_steps_q, ramp_steps_d;
  logic [SPEED_W-1:0] vmax_q, vmax_d;
  logic               dir_q, dir_d;
  logic               aborted_q, aborted_d;
  logic               step_q;

  logic               accept;
  logic               moving;
  logic               step_edge;
  logic [SPEED_W-1:0] speed;

  assign step_edge = step_fb & ~step_q;

  stepper_ramp_gen #(
    .ACCEL_DIV  (ACCEL_DIV),
    .ACCEL_STEP (ACCEL_STEP),
    .SPEED_MIN  (SPEED_MIN)
  ) u_ramp (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .run_i   (busy),
    .load_i  (accept),
    .up_i    (state_q == ACCEL),
    .down_i  (state_q == DECEL),
    .vmax_i  (vmax_q),
    .speed_o (speed)
  );

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    ramp_steps_d = ramp_steps_q;
    vmax_d       = vmax_q;
    dir_d        = dir_q;
    aborted_d    = aborted_q;

    moving     = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);
    accept     = cmd_valid && (state_q == IDLE);
    cmd_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    drv_run_en = moving;
    drv_speed  = moving ? speed : '0;
    drv_dir    = dir_q;
    done       = (state_q == FINISH);
    aborted    = (state_q == FINISH) && aborted_q;
    steps_left = steps_left_q;

    // ramp_steps records how many steps the ramp-up consumed. The ramp-down needs
    // about the same number, so braking starts once steps_left falls to that count.
    if (moving && step_edge) begin
      steps_left_d = (steps_left_q == '0) ? '0 : steps_left_q - CNT_W'(1);
      if (state_q == ACCEL) ramp_steps_d = ramp_steps_q + CNT_W'(1);
    end

    // The branch order in each moving state sets the priority:
    // count exhausted, then abort, then the ramp transition.
    case (state_q)
      IDLE: begin
        if (accept) begin
          steps_left_d = cmd_steps;
          dir_d        = cmd_dir;
          vmax_d       = (cmd_vmax < SPEED_MIN) ? SPEED_MIN : cmd_vmax;
          ramp_steps_d = '0;
          aborted_d    = 1'b0;
          state_d      = (cmd_steps == '0) ? FINISH : ACCEL;
        end
      end
      ACCEL: begin
        if (steps_left_q == '0) begin
          state_d = FINISH;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = DECEL;
        end else if (steps_left_q <= ramp_steps_q) begin
          state_d = DECEL;
        end else if (speed == vmax_q) begin
          state_d = CRUISE;
        end
      end
      CRUISE: begin
        if (steps_left_q == '0) begin
          state_d = FINISH;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = DECEL;
        end else if (steps_left_q <= ramp_steps_q) begin
          state_d = DECEL;
        end
      end
      DECEL: begin
        if (steps_left_q == '0) begin
          state_d = FINISH;
        end else begin
          // An abort during a normal ramp-down also ends the move early, once the ramp is at the floor.
          if (abort) aborted_d = 1'b1;
          if ((abort || aborted_q) && (speed == SPEED_MIN)) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      steps_left_q <= '0;
      ramp_steps_q <= '0;
      vmax_q       <= '0;
      dir_q        <= 1'b0;
      aborted_q    <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      ramp_steps_q <= ramp_steps_d;
      vmax_q       <= vmax_d;
      dir_q        <= dir_d;
      aborted_q    <= aborted_d;
      step_q       <= step_fb;
    end
  end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Purpose : scoreboard bench for stepper_move_sequencer with a speed-driven step/dir driver model.
// Latency : n/a.
// Backpressure: n/a.
module tb_stepper_move_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [9:0]  cmd_vmax = '0;
  logic        abort = 1'b0;
  logic        step_fb = 1'b0;
  logic [9:0]  drv_speed;
  logic        drv_dir;
  logic        drv_run_en;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [23:0] steps_left;

  stepper_move_sequencer #(
    .ACCEL_DIV  (100),
    .ACCEL_STEP (10'd10),
    .SPEED_MIN  (10'd50),
    .CNT_W      (24)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_vmax   (cmd_vmax),
    .abort      (abort),
    .step_fb    (step_fb),
    .drv_speed  (drv_speed),
    .drv_dir    (drv_dir),
    .drv_run_en (drv_run_en),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_left (steps_left)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    int steps;
    bit aborted;
    int done_cyc;   // -1: latency not checked
    bit moves;
    int max_lo;
    int max_hi;
    bit ramp_seq;
    bit dir;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Driver model: one step every 5000/speed cycles, 2-cycle high pulse.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clock);
      if (!drv_run_en || drv_speed == 0) begin
        ph = 0;
        step_fb = 1'b0;
      end else begin
        ph++;
        if (ph >= 5000 / int'(drv_speed)) begin
          step_fb = 1'b1;
          ph = 0;
        end else if (ph >= 2) begin
          step_fb = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard checker.
  logic m_prev_busy = 1'b0;
  logic m_prev_fb = 1'b0;
  int   m_edges = 0;
  int   m_max = 0;
  int   m_min = 1023;
  bit   m_run = 1'b0;
  int   m_spd[$];
  exp_t m_e;

  initial forever begin
    @(posedge clock);
    #1;
    if (!reset_n) begin
      chk("rst_run_en", drv_run_en, 0);
      chk("rst_speed", drv_speed, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_steps_left", steps_left, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      m_prev_busy = 1'b0;
      m_prev_fb = step_fb;
      continue;
    end
    if (busy && !m_prev_busy) begin
      m_edges = 0; m_max = 0; m_min = 1023; m_run = 1'b0;
      m_spd.delete();
    end
    if (busy) begin
      if (step_fb && !m_prev_fb) m_edges++;
      if (drv_run_en) begin
        m_run = 1'b1;
        if (int'(drv_speed) > m_max) m_max = int'(drv_speed);
        if (int'(drv_speed) < m_min) m_min = int'(drv_speed);
        if (m_spd.size() == 0 || m_spd[$] != int'(drv_speed)) m_spd.push_back(int'(drv_speed));
      end
    end
    if (cmd_valid) chk("cmd_ready_vs_busy", cmd_ready, {31'd0, !busy});
    if (done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: actual done=1 at cycle %0d, required no done", cyc);
      end else begin
        m_e = sbq.pop_front();
        chk("aborted_flag", aborted, m_e.aborted);
        chk("drv_dir_latched", drv_dir, m_e.dir);
        chk("run_seen", m_run, m_e.moves);
        if (m_e.done_cyc >= 0) chk("done_latency", cyc, m_e.done_cyc);
        if (!m_e.aborted) begin
          chk("steps_left_end", steps_left, 0);
          chk("step_edges", m_edges, m_e.steps);
        end else begin
          chk_range("steps_left_abort", int'(steps_left), 1, m_e.steps);
          chk("edges_plus_left", m_edges + int'(steps_left), m_e.steps);
          chk("abort_final_speed", (m_spd.size() > 0) ? m_spd[$] : -1, 50);
        end
        if (m_e.moves) begin
          chk_range("min_speed", m_min, 50, 1023);
          chk_range("peak_speed", m_max, m_e.max_lo, m_e.max_hi);
        end
        if (m_e.ramp_seq) begin
          for (int k = 0; k < 6; k++)
            chk($sformatf("ramp_speed_%0d", k), (m_spd.size() > k) ? m_spd[k] : -1, 50 + 10 * k);
        end
      end
    end
    m_prev_busy = busy;
    m_prev_fb = step_fb;
  end

  function automatic exp_t mk(input int steps, input bit ab, input bit moves, input int lo,
                              input int hi, input bit ramp, input bit dir);
    exp_t e;
    e.steps = steps; e.aborted = ab; e.done_cyc = -1; e.moves = moves;
    e.max_lo = lo; e.max_hi = hi; e.ramp_seq = ramp; e.dir = dir;
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50000) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: actual cmd_ready=0, required 1");
    end
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: actual %0d moves pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_speed(input int v, input int budget);
    int n = 0;
    while (int'(drv_speed) != v && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (int'(drv_speed) != v) begin
      n_chk++; n_fail++;
      $display("FAIL speed_timeout: actual %0d, required %0d", drv_speed, v);
    end
  endtask

  // Issue one command. chk_lat: expect done right after the accept edge.
  // hold: keep cmd_valid high until done is seen.
  task automatic issue(input int steps, input bit dir, input int vmax, input bit hold,
                       input bit chk_lat, input exp_t e_in);
    exp_t e;
    int   n;
    e = e_in;
    wait_ready();
    @(negedge clock);
    cmd_steps = steps[23:0];
    cmd_dir   = dir;
    cmd_vmax  = vmax[9:0];
    cmd_valid = 1'b1;
    e.done_cyc = chk_lat ? cyc + 1 : -1;
    sbq.push_back(e);
    if (!hold) begin
      @(negedge clock);
      cmd_valid = 1'b0;
    end else begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!done && n < 20000);
      cmd_valid = 1'b0;
      if (!done) begin
        n_chk++; n_fail++;
        $display("FAIL hold_done_timeout: actual done=0, required 1");
      end
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // 1: reset mid-move, during cruise; no done may follow.
    wait_ready();
    @(negedge clock);
    cmd_steps = 24'd400; cmd_dir = 1'b1; cmd_vmax = 10'd100; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_speed(100, 2000);
    repeat (50) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_run_en", drv_run_en, 0);

    // 2: long move with full ramp.
    issue(400, 1'b1, 100, 1'b0, 1'b0, mk(400, 1'b0, 1'b1, 100, 100, 1'b1, 1'b1));
    wait_empty(40000);

    // 3: short move, braking before vmax.
    issue(6, 1'b0, 500, 1'b0, 1'b0, mk(6, 1'b0, 1'b1, 50, 490, 1'b0, 1'b0));
    wait_empty(5000);

    // 4: zero move.
    issue(0, 1'b1, 100, 1'b0, 1'b1, mk(0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1));
    wait_empty(100);

    // 5: abort in cruise, then a clean move.
    issue(1000, 1'b1, 200, 1'b0, 1'b0, mk(1000, 1'b1, 1'b1, 200, 200, 1'b0, 1'b1));
    wait_speed(200, 3000);
    repeat (100) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    wait_empty(5000);
    issue(3, 1'b0, 60, 1'b0, 1'b0, mk(3, 1'b0, 1'b1, 50, 60, 1'b0, 1'b0));
    wait_empty(5000);

    // 6: cmd_valid held through the move, vmax=0 cruises at SPEED_MIN.
    issue(5, 1'b1, 0, 1'b1, 1'b0, mk(5, 1'b0, 1'b1, 50, 50, 1'b0, 1'b1));
    wait_empty(5000);
    repeat (20) @(negedge clock);
    chk("no_reaccept_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
